// File: rtl/stg_ifq_pkg.sv
// Shared sizes and the instruction-queue entry layout for the fetch stage.
package stg_ifq_pkg;
  localparam int SIZE_DATA = 32;
  localparam int SIZE_ADDR = 16;
  localparam int HBIT_DATA = SIZE_DATA - 1;
  localparam int HBIT_ADDR = SIZE_ADDR - 1;

  typedef struct packed {
    logic [HBIT_ADDR:0] pc;
    logic [HBIT_DATA:0] instr;
  } ifq_entry_t;

  localparam int ENTRY_W = $bits(ifq_entry_t);
endpackage

// File: rtl/ifq_ram.sv
// Entry storage for the fetch queue: FETCH_W write lanes, one asynchronous read port.
module ifq_ram
  import stg_ifq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int FETCH_W = 2
) (
  input  logic                               iw_clk,
  input  logic                               iw_rst_n,
  input  logic [FETCH_W-1:0]                 iw_we,
  input  logic [FETCH_W*$clog2(DEPTH)-1:0]   iw_waddr,
  input  logic [FETCH_W*ENTRY_W-1:0]         iw_wdata,
  input  logic [$clog2(DEPTH)-1:0]           iw_raddr,
  output ifq_entry_t                         ow_rdata
);
  localparam int PTR_W = $clog2(DEPTH);

  ifq_entry_t mem_reg [DEPTH];

  // Lanes never alias: a group is at most FETCH_W <= DEPTH consecutive slots.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_reg[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int l = 0; l < FETCH_W; l++) begin
          if (iw_we[l] && (iw_waddr[l*PTR_W +: PTR_W] == PTR_W'(e))) begin
            mem_reg[e] <= iw_wdata[l*ENTRY_W +: ENTRY_W];
          end
        end
      end
    end
  end

  assign ow_rdata = mem_reg[iw_raddr];
endmodule

// File: rtl/stg_ifq.sv
// Fetch-to-decode instruction queue with multi-word push and single-word pop.
// Optional performance counters are enabled with the STG_IFQ_PERF_EN macro.
module stg_ifq
  import stg_ifq_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int DEPTH   = 4
) (
  input  logic                         iw_clk,
  input  logic                         iw_rst_n,
  input  logic [FETCH_W*SIZE_DATA-1:0] iw_mem_data,
  input  logic                         iw_ia_valid,
  input  logic [$clog2(FETCH_W):0]     iw_ia_cnt,
  input  logic [HBIT_ADDR:0]           iw_pc,
  input  logic                         iw_flush,
  input  logic                         iw_id_ready,
  output logic                         ow_ia_ready,
  output logic                         ow_valid,
  output logic [HBIT_ADDR:0]           ow_pc,
  output logic [HBIT_DATA:0]           ow_instr,
  output logic [31:0]                  ow_stall_cnt,
  output logic [15:0]                  ow_flush_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IAC_W = $clog2(FETCH_W) + 1;

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop;

  logic [FETCH_W-1:0]         lane_we;
  logic [FETCH_W*PTR_W-1:0]   lane_addr;
  logic [FETCH_W*ENTRY_W-1:0] lane_data;
  ifq_entry_t                 head;

  // Ready looks only at the registered count; a same-cycle pop earns no credit.
  assign ow_ia_ready = (count_reg <= CNT_W'(DEPTH - FETCH_W));
  assign ow_valid    = (count_reg != '0);

  always_comb begin
    push        = iw_ia_valid && ow_ia_ready && !iw_flush;
    pop         = ow_valid && iw_id_ready && !iw_flush;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (iw_flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(iw_ia_cnt);
        count_next  = count_next + CNT_W'(iw_ia_cnt);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        count_next  = count_next - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
    assign lane_we[gi]                     = push && (iw_ia_cnt > IAC_W'(gi));
    assign lane_addr[gi*PTR_W +: PTR_W]    = wr_ptr_reg + PTR_W'(gi);
    assign lane_data[gi*ENTRY_W +: ENTRY_W] =
      {iw_pc + SIZE_ADDR'(gi), iw_mem_data[gi*SIZE_DATA +: SIZE_DATA]};
  end

  ifq_ram #(
    .DEPTH   (DEPTH),
    .FETCH_W (FETCH_W)
  ) u_ram (
    .iw_clk   (iw_clk),
    .iw_rst_n (iw_rst_n),
    .iw_we    (lane_we),
    .iw_waddr (lane_addr),
    .iw_wdata (lane_data),
    .iw_raddr (rd_ptr_reg),
    .ow_rdata (head)
  );

  // Popped slots keep stale data, so an empty queue must present a zero bubble.
  assign ow_pc    = ow_valid ? head.pc    : '0;
  assign ow_instr = ow_valid ? head.instr : '0;

`ifdef STG_IFQ_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [15:0] flush_cnt_reg;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (iw_ia_valid && !ow_ia_ready && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (iw_flush && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end
    end
  end

  assign ow_stall_cnt = stall_cnt_reg;
  assign ow_flush_cnt = flush_cnt_reg;
`else
  assign ow_stall_cnt = '0;
  assign ow_flush_cnt = '0;
`endif

  a_ia_cnt_legal: assert property (@(posedge iw_clk) disable iff (!iw_rst_n)
    iw_ia_valid |-> ((iw_ia_cnt != '0) && (iw_ia_cnt <= IAC_W'(FETCH_W))));

  a_count_bound: assert property (@(posedge iw_clk) disable iff (!iw_rst_n)
    count_reg <= CNT_W'(DEPTH));
endmodule
